// File: rtl/pc_seq_pkg.sv
// Shared types and the branch-target helper for the program-counter sequencer.
// The helper works at a wide fixed width so any PC_WIDTH can truncate its result.
package pc_seq_pkg;

  localparam int unsigned MAX_PC_WIDTH = 128;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    RET    = 2'd2,
    HOLDPC = 2'd3
  } pc_sel_e;

  // Modulo addition: the low PC_WIDTH bits of the wide sum are the wrapped target.
  function automatic logic [MAX_PC_WIDTH-1:0] branch_target(
    input logic [MAX_PC_WIDTH-1:0] pc,
    input logic [MAX_PC_WIDTH-1:0] imm,
    input int unsigned             shift
  );
    return pc + (imm << shift);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, replace-top (push+pop), saturating count.
// A pop on an empty stack raises a registered one-cycle underflow pulse.
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             underflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, top_idx_s, wr_idx_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en_s, underflow_d, underflow_q, empty_s;

  assign empty_s   = (cnt_q == {CW{1'b0}});
  assign top_idx_s = ptr_q - PW'(1'b1);

  // Next pointer/count and the single write port for push or replace.
  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wr_en_s     = 1'b0;
    wr_idx_s    = ptr_q;
    underflow_d = pop_i && empty_s;
    if (push_i && pop_i) begin
      wr_en_s = 1'b1;
      if (empty_s) begin
        wr_idx_s = ptr_q;
        ptr_d    = ptr_q + PW'(1'b1);
        cnt_d    = CW'(1'b1);
      end else begin
        wr_idx_s = top_idx_s;
      end
    end else if (push_i) begin
      // When full the write lands on the oldest entry and the count saturates.
      wr_en_s  = 1'b1;
      wr_idx_s = ptr_q;
      ptr_d    = ptr_q + PW'(1'b1);
      if (cnt_q != CW'(DEPTH)) begin
        cnt_d = cnt_q + CW'(1'b1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop_i) begin
      if (!empty_s) begin
        ptr_d = top_idx_s;
        cnt_d = cnt_q - CW'(1'b1);
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Stack storage, pointer, count and underflow pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      ptr_q       <= {PW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      underflow_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_idx_s] <= data_i;
      end
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign top_o       = mem_q[top_idx_s];
  assign empty_o     = empty_s;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with branch, call/return via a RAS, stall, halt and post-reset hold.
// Define MISALIGN_TRAP_EN to redirect misaligned non-sequential targets to TRAP_PC and expose Fault.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = {PC_WIDTH{1'b0}},
  parameter int unsigned         INSTR_BYTES  = 4,
  parameter int unsigned         OFFSET_SHIFT = 0,
  parameter int unsigned         RAS_DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] TRAP_PC      = PC_WIDTH'(32'h100)
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                Halt,
  input  logic                Resume,
  input  logic                Branch,
  input  logic                ALUZero,
  input  logic                Uncondbranch,
  input  logic                Call,
  input  logic                Return,
  input  logic [PC_WIDTH-1:0] SignExtImm,
  input  logic [PC_WIDTH-1:0] RegTarget,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] NextPC,
  output logic                FetchValid,
  output logic                Halted,
  output logic                RasEmpty,
  output logic                RasUnderflow
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                Fault
`endif
);

  seq_state_e          state_q, state_d;
  pc_sel_e             sel_s;
  logic [PC_WIDTH-1:0] pc_q, next_pc_s, seq_pc_s, br_tgt_s, raw_tgt_s, ras_top_s;
  logic                fetch_valid_q, halted_q;
  logic                run_s, push_s, pop_s, ras_empty_s, ras_underflow_s;

  // A cycle only commits work in RUN with neither Halt nor Stall asserted.
  assign run_s    = (state_q == RUN) && !Halt && !Stall;
  assign push_s   = run_s && Call;
  assign pop_s    = run_s && Return;
  assign seq_pc_s = pc_q + PC_WIDTH'(INSTR_BYTES);
  assign br_tgt_s = PC_WIDTH'(branch_target(MAX_PC_WIDTH'(pc_q), MAX_PC_WIDTH'(SignExtImm),
                                            OFFSET_SHIFT));

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .clk_i       (CLK),
    .rst_i       (Reset),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .data_i      (seq_pc_s),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s),
    .underflow_o (ras_underflow_s)
  );

  // State register with registered status flags.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= HOLD;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= (state_d == RUN);
      halted_q      <= (state_d == HALT);
    end
  end

  // Next-state logic; Halt beats Resume when both are high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD: state_d = RUN;
      RUN: begin
        if (Halt) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (Resume && !Halt) begin
          state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // Next-PC source selection in priority order.
  always_comb begin
    sel_s = HOLDPC;
    if (!run_s) begin
      sel_s = HOLDPC;
    end else if (Return) begin
      sel_s = RET;
    end else if (Call || Uncondbranch || (Branch && ALUZero)) begin
      sel_s = BRANCH;
    end else begin
      sel_s = SEQ;
    end
  end

  // Target mux; an empty stack falls back to RegTarget.
  always_comb begin
    raw_tgt_s = pc_q;
    case (sel_s)
      SEQ:     raw_tgt_s = seq_pc_s;
      BRANCH:  raw_tgt_s = br_tgt_s;
      RET: begin
        if (ras_empty_s) begin
          raw_tgt_s = RegTarget;
        end else begin
          raw_tgt_s = ras_top_s;
        end
      end
      HOLDPC:  raw_tgt_s = pc_q;
      default: raw_tgt_s = pc_q;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 32'd1);

  logic misalign_s, fault_q;

  assign misalign_s = ((sel_s == BRANCH) || (sel_s == RET)) && (|(raw_tgt_s & ALIGN_MASK));
  assign next_pc_s  = misalign_s ? TRAP_PC : raw_tgt_s;

  // Sticky fault, cleared only by Reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else if (misalign_s) begin
      fault_q <= 1'b1;
    end else begin
      fault_q <= fault_q;
    end
  end

  assign Fault = fault_q;
`else
  logic unused_trap_s;

  assign next_pc_s     = raw_tgt_s;
  assign unused_trap_s = ^TRAP_PC;
`endif

  // Architectural PC register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc_s;
    end
  end

  assign PC           = pc_q;
  assign NextPC       = next_pc_s;
  assign FetchValid   = fetch_valid_q;
  assign Halted       = halted_q;
  assign RasEmpty     = ras_empty_s;
  assign RasUnderflow = ras_underflow_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written multi-cycle sequences and
// randomized stimulus checked against a queue-based reference model (MISALIGN_TRAP_EN aware).
module tb_pc_sequencer;

  localparam logic [7:0] C_STALL = 8'h80, C_HALT = 8'h40, C_RES = 8'h20, C_BR = 8'h10;
  localparam logic [7:0] C_Z = 8'h08, C_UNC = 8'h04, C_CALL = 8'h02, C_RET = 8'h01;
  localparam int S_HOLD = 0, S_RUN = 1, S_HALT = 2;

  typedef struct {
    logic [7:0]  ctl;   // {stall, halt, resume, branch, aluzero, uncond, call, ret}
    logic [63:0] imm;
    logic [63:0] regt;
  } in_t;

  typedef struct {
    in_t         in;
    logic [63:0] exp_pc;
    logic        exp_empty;
    logic        exp_unf;
  } vec_t;

  logic        CLK = 1'b0, Reset = 1'b1;
  logic        Stall = 1'b0, Halt = 1'b0, Resume = 1'b0, Branch = 1'b0, ALUZero = 1'b0;
  logic        Uncondbranch = 1'b0, Call = 1'b0, Return = 1'b0;
  logic [63:0] SignExtImm = 64'd0, RegTarget = 64'd0;
  logic [63:0] PC, NextPC;
  logic        FetchValid, Halted, RasEmpty, RasUnderflow;
`ifdef MISALIGN_TRAP_EN
  logic        Fault;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [63:0] m_pc = 64'd0;
  int          m_state = S_HOLD;
  logic [63:0] m_ras[$];
  logic        m_unf = 1'b0;
  logic        m_fault = 1'b0;

  pc_sequencer dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Stall        (Stall),
    .Halt         (Halt),
    .Resume       (Resume),
    .Branch       (Branch),
    .ALUZero      (ALUZero),
    .Uncondbranch (Uncondbranch),
    .Call         (Call),
    .Return       (Return),
    .SignExtImm   (SignExtImm),
    .RegTarget    (RegTarget),
    .PC           (PC),
    .NextPC       (NextPC),
    .FetchValid   (FetchValid),
    .Halted       (Halted),
    .RasEmpty     (RasEmpty),
    .RasUnderflow (RasUnderflow)
`ifdef MISALIGN_TRAP_EN
    ,
    .Fault        (Fault)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk(input logic [7:0] ctl, input logic [63:0] imm, input logic [63:0] regt);
    in_t r;
    r.ctl = ctl;
    r.imm = imm;
    r.regt = regt;
    return r;
  endfunction

  function automatic vec_t mkv(input in_t i, input logic [63:0] pc, input logic e, input logic u);
    vec_t v;
    v.in = i;
    v.exp_pc = pc;
    v.exp_empty = e;
    v.exp_unf = u;
    return v;
  endfunction

  // Architectural rules: what PC becomes after this cycle.
  function automatic logic [63:0] model_next(input in_t v, output logic trap);
    logic [63:0] t;
    trap = 1'b0;
    if (m_state != S_RUN || v.ctl[6] || v.ctl[7]) return m_pc;
    if (v.ctl[0]) t = (m_ras.size() == 0) ? v.regt : m_ras[$];
    else if (v.ctl[1] || v.ctl[2] || (v.ctl[4] && v.ctl[3])) t = m_pc + v.imm;
    else return m_pc + 64'd4;
`ifdef MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) begin
      t = 64'h100;
      trap = 1'b1;
    end
`endif
    return t;
  endfunction

  task automatic model_commit(input in_t v);
    logic        trap;
    logic [63:0] n;
    logic        run;
    n = model_next(v, trap);
    run = (m_state == S_RUN) && !v.ctl[6] && !v.ctl[7];
    m_unf = run && v.ctl[0] && (m_ras.size() == 0);
    if (run && v.ctl[0] && m_ras.size() > 0) void'(m_ras.pop_back());
    if (run && v.ctl[1]) begin
      m_ras.push_back(m_pc + 64'd4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
    if (trap) m_fault = 1'b1;
    case (m_state)
      S_HOLD:  m_state = S_RUN;
      S_RUN:   m_state = v.ctl[6] ? S_HALT : S_RUN;
      default: m_state = (v.ctl[5] && !v.ctl[6]) ? S_RUN : S_HALT;
    endcase
    m_pc = n;
  endtask

  task automatic model_reset();
    m_pc = 64'd0;
    m_state = S_HOLD;
    m_ras.delete();
    m_unf = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string nm);
    check({nm, " PC"}, PC, m_pc);
    check({nm, " FetchValid"}, 64'(FetchValid), 64'(m_state == S_RUN));
    check({nm, " Halted"}, 64'(Halted), 64'(m_state == S_HALT));
    check({nm, " RasEmpty"}, 64'(RasEmpty), 64'(m_ras.size() == 0));
    check({nm, " RasUnderflow"}, 64'(RasUnderflow), 64'(m_unf));
`ifdef MISALIGN_TRAP_EN
    check({nm, " Fault"}, 64'(Fault), 64'(m_fault));
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply(input in_t v, input string nm);
    logic trap;
    {Stall, Halt, Resume, Branch, ALUZero, Uncondbranch, Call, Return} = v.ctl;
    SignExtImm = v.imm;
    RegTarget = v.regt;
    #1;
    check({nm, " NextPC"}, NextPC, model_next(v, trap));
    @(posedge CLK);
    model_commit(v);
    #1;
    check_state(nm);
    @(negedge CLK);
  endtask

  vec_t tbl[19];

  initial begin
    tbl[0]  = mkv(mk(8'h00, 64'd4, 64'd0), 64'd0, 1'b1, 1'b0);
    tbl[1]  = mkv(mk(8'h00, 64'd4, 64'd0), 64'd4, 1'b1, 1'b0);
    tbl[2]  = mkv(mk(C_UNC, 64'd12, 64'd0), 64'd16, 1'b1, 1'b0);
    tbl[3]  = mkv(mk(C_BR, 64'd16, 64'd0), 64'd20, 1'b1, 1'b0);
    tbl[4]  = mkv(mk(C_BR | C_Z, 64'hFFFF_FFFF_FFFF_FFF4, 64'd0), 64'd8, 1'b1, 1'b0);
    tbl[5]  = mkv(mk(C_CALL, 64'd40, 64'd0), 64'd48, 1'b0, 1'b0);
    tbl[6]  = mkv(mk(C_RET, 64'd0, 64'd0), 64'd12, 1'b1, 1'b0);
    tbl[7]  = mkv(mk(C_RET, 64'd0, 64'd200), 64'd200, 1'b1, 1'b1);
    tbl[8]  = mkv(mk(8'h00, 64'd0, 64'd0), 64'd204, 1'b1, 1'b0);
    tbl[9]  = mkv(mk(C_STALL | C_UNC, 64'd100, 64'd0), 64'd204, 1'b1, 1'b0);
    tbl[10] = mkv(mk(C_HALT | C_UNC, 64'd100, 64'd0), 64'd204, 1'b1, 1'b0);
    tbl[11] = mkv(mk(C_HALT | C_RES, 64'd100, 64'd0), 64'd204, 1'b1, 1'b0);
    tbl[12] = mkv(mk(C_RES | C_CALL, 64'd100, 64'd0), 64'd204, 1'b1, 1'b0);
    tbl[13] = mkv(mk(8'h00, 64'd0, 64'd0), 64'd208, 1'b1, 1'b0);
    tbl[14] = mkv(mk(C_UNC, 64'hFFFF_FFFF_FFFF_FF2C, 64'd0), 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
    tbl[15] = mkv(mk(8'h00, 64'd0, 64'd0), 64'd0, 1'b1, 1'b0);
    tbl[16] = mkv(mk(C_CALL, 64'd8, 64'd0), 64'd8, 1'b0, 1'b0);
    tbl[17] = mkv(mk(C_CALL | C_RET, 64'd100, 64'd0), 64'd4, 1'b0, 1'b0);
    tbl[18] = mkv(mk(C_RET, 64'd0, 64'd0), 64'd12, 1'b1, 1'b0);

    @(negedge CLK);
    check_state("reset");
    check("reset NextPC", NextPC, 64'd0);
    Reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].in, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d exp PC", i), PC, tbl[i].exp_pc);
      check($sformatf("tbl%0d exp empty", i), 64'(RasEmpty), 64'(tbl[i].exp_empty));
      check($sformatf("tbl%0d exp unf", i), 64'(RasUnderflow), 64'(tbl[i].exp_unf));
    end

    // Five calls from PC=12 overflow a four-entry stack; the oldest link is lost.
    for (int k = 0; k < 5; k++) begin
      apply(mk(C_CALL, 64'd8, 64'd0), $sformatf("call%0d", k));
      check($sformatf("call%0d exp PC", k), PC, 64'd20 + 64'(8 * k));
    end
    for (int k = 0; k < 4; k++) begin
      apply(mk(C_RET, 64'd0, 64'd0), $sformatf("ret%0d", k));
      check($sformatf("ret%0d exp PC", k), PC, 64'd48 - 64'(8 * k));
    end
    apply(mk(C_RET, 64'd0, 64'd200), "ret_unf");
    check("ret_unf exp PC", PC, 64'd200);
    check("ret_unf pulse", 64'(RasUnderflow), 64'd1);
    apply(mk(8'h00, 64'd0, 64'd0), "after_unf");
    check("after_unf pulse", 64'(RasUnderflow), 64'd0);

    // Stall three cycles, then halt with a pending call, then reset asynchronously mid-HALT.
    for (int k = 0; k < 3; k++) begin
      apply(mk(C_STALL | C_UNC, 64'd64, 64'd0), $sformatf("stall%0d", k));
      check($sformatf("stall%0d exp PC", k), PC, 64'd204);
    end
    apply(mk(C_CALL, 64'd16, 64'd0), "pre_halt");
    apply(mk(C_HALT, 64'd0, 64'd0), "halt");
    apply(mk(C_UNC, 64'd64, 64'd0), "in_halt");
    check("in_halt exp PC", PC, 64'd220);
    check("in_halt Halted", 64'(Halted), 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_state("async_reset");
    @(negedge CLK);
    Reset = 1'b0;
    apply(mk(8'h00, 64'd4, 64'd0), "hold_again");

`ifdef MISALIGN_TRAP_EN
    apply(mk(C_UNC, 64'd6, 64'd0), "trap");
    check("trap exp PC", PC, 64'h100);
    check("trap Fault", 64'(Fault), 64'd1);
    apply(mk(8'h00, 64'd0, 64'd0), "trap_sticky");
`endif

    for (int i = 0; i < 400; i++) begin
      in_t r;
      r.ctl = 8'h00;
      r.ctl[7] = ($urandom_range(0, 9) == 0);
      r.ctl[6] = ($urandom_range(0, 19) == 0);
      r.ctl[5] = ($urandom_range(0, 2) == 0);
      r.ctl[4] = ($urandom_range(0, 3) == 0);
      r.ctl[3] = ($urandom_range(0, 1) == 0);
      r.ctl[2] = ($urandom_range(0, 7) == 0);
      r.ctl[1] = ($urandom_range(0, 4) == 0);
      r.ctl[0] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) r.imm = {$urandom, $urandom};
      else r.imm = 64'($urandom_range(0, 63)) * 64'd4 - 64'd128;
      r.regt = {$urandom, $urandom};
      apply(r, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit; parametrised successor to the combinational next-PC logic.
- Holds the architectural PC and computes the next PC:
  - sequential increment
  - conditional branch (Branch & ALUZero)
  - unconditional branch
  - call/return through an internal return-address stack (RAS)
- Adds stall, halt/resume and a post-reset hold state.
- Sits between the instruction memory address port and the control/ALU zero feedback.

Parameters:
- PC_WIDTH, 64, width of PC, immediate and targets.
- RESET_PC, 0, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment.
- OFFSET_SHIFT, 0, left shift applied to SignExtImm before adding to PC.
- RAS_DEPTH, 4, return-address-stack entries; power of two, minimum 2.
- TRAP_PC, 'h100, vector used by the optional misalignment trap.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hold PC and RAS this cycle.
- Halt  input  1  enter HALT state.
- Resume  input  1  leave HALT state.
- Branch  input  1  conditional branch instruction.
- ALUZero  input  1  ALU zero flag.
- Uncondbranch  input  1  unconditional branch.
- Call  input  1  branch-and-link: jump to PC+offset and push PC+INSTR_BYTES.
- Return  input  1  pop RAS and jump to the popped address.
- SignExtImm  input  PC_WIDTH  sign-extended branch offset.
- RegTarget  input  PC_WIDTH  fallback return target used on RAS underflow.
- PC  output  PC_WIDTH  registered current PC.
- NextPC  output  PC_WIDTH  combinational value PC will take at the next edge.
- FetchValid  output  1  PC addresses a valid instruction.
- Halted  output  1  high in HALT.
- RasEmpty  output  1  RAS count is zero.
- RasUnderflow  output  1  one-cycle pulse, registered.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - PC=RESET_PC, state=HOLD, RAS count=0, RAS pointer=0
  - FetchValid=0, Halted=0, RasUnderflow=0, RasEmpty=1
- States:
  - HOLD:
    - Exactly one cycle after reset is released.
    - PC stays RESET_PC, then go to RUN.
  - RUN:
    - FetchValid=1.
    - Halt=1 → HALT at the next edge; PC is frozen, the current instruction's update is discarded.
  - HALT:
    - FetchValid=0, Halted=1, PC frozen, all control inputs ignored.
    - Resume=1 → RUN.
    - Halt and Resume both high → stay HALT.
- NextPC priority in RUN (highest first):
  1. Stall → NextPC=PC; RAS unchanged.
  2. Return → popped RAS top. If the RAS is empty: RegTarget is used and RasUnderflow pulses next cycle.
  3. Call, Uncondbranch, or (Branch & ALUZero) → PC + (SignExtImm << OFFSET_SHIFT).
  4. Otherwise → PC + INSTR_BYTES.
- In HOLD and HALT, NextPC=PC.
- Arithmetic: modulo 2^PC_WIDTH; wrap-around silently; no carry out.
- RAS is circular:
  - Call pushes PC+INSTR_BYTES.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop decrements count.
  - Call and Return in the same cycle: Return wins for NextPC; the stack replaces its top with PC+INSTR_BYTES (pop then push, count unchanged). If empty, count becomes 1.
- Reset asserted mid-operation immediately clears everything regardless of state.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Any non-sequential target whose low log2(INSTR_BYTES) bits are nonzero redirects NextPC to TRAP_PC.
  - Extra output Fault (1 bit) is set sticky and cleared only by Reset.
- Undefined:
  - Targets are used unmodified.
  - No Fault port.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum: HOLD, RUN, HALT
  - selector enum for the next-PC source: SEQ, BRANCH, RET, HOLDPC
  - helper function computing the branch target
- Sub-module pc_ras (return address stack with push, pop, replace, empty and underflow outputs) is natural; the top level keeps the state machine and the adder/mux.

Test Plan:
- Reset, release, then Branch=0, SignExtImm=4 → HOLD for 1 cycle with PC=0 and FetchValid=0; next edge PC=0; NextPC=4; following edge PC=4.
- PC=0, SignExtImm=16, ALUZero=1, Uncondbranch=1 → NextPC=16; also Branch=1, ALUZero=0, SignExtImm=16 from PC=16 → NextPC=20 (not taken).
- Call at PC=8 with SignExtImm=40 → PC=48, RAS top=12; Return → PC=12, RasEmpty=1; second Return with RegTarget=200 → PC=200, RasUnderflow pulses one cycle.
- Five Calls with RAS_DEPTH=4 → four Returns yield the last four link addresses in LIFO order, then underflow.
- Stall=1 for 3 cycles at PC=20 with Uncondbranch=1 → PC stays 20; Halt then Resume → PC frozen and Halted=1 while in HALT; Reset asserted mid-HALT → PC=0 asynchronously.
- MISALIGN_TRAP_EN defined: Uncondbranch, PC=0, SignExtImm=6 → PC=TRAP_PC ('h100), Fault=1 until Reset.
